// File: rtl/alu_seq.sv
// alu_seq: registered multi-cycle ALU with a START/BUSY/DONE handshake.
// Single-cycle legacy opcodes 0..15 complete in one edge. MUL (16) runs a
// shift-add loop for WIDTH cycles. DIV (17) runs a restoring divider for
// WIDTH cycles and is compiled only when ALU_SEQ_DIV_EN is defined;
// otherwise SEL=17 is treated as a reserved opcode.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [4:0]       sel_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             c_o,
    output logic             z_o
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;
    localparam int unsigned W1 = WIDTH + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_ADDC = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_SUBC = 5'd3;
    localparam logic [4:0] OP_CMP  = 5'd4;
    localparam logic [4:0] OP_AND  = 5'd5;
    localparam logic [4:0] OP_OR   = 5'd6;
    localparam logic [4:0] OP_XOR  = 5'd7;
    localparam logic [4:0] OP_TEST = 5'd8;
    localparam logic [4:0] OP_LSL  = 5'd9;
    localparam logic [4:0] OP_LSR  = 5'd10;
    localparam logic [4:0] OP_ROL  = 5'd11;
    localparam logic [4:0] OP_ROR  = 5'd12;
    localparam logic [4:0] OP_ASR  = 5'd13;
    localparam logic [4:0] OP_MOV  = 5'd14;
    localparam logic [4:0] OP_MUL  = 5'd16;
`ifdef ALU_SEQ_DIV_EN
    localparam logic [4:0] OP_DIV  = 5'd17;
`endif

    logic [0:0]       state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             c_q, c_d;
    logic             z_q, z_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
`ifdef ALU_SEQ_DIV_EN
    logic             is_div_q, is_div_d;
`endif

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c;
    logic             sc_keep_c;
    logic             sc_iter;

    logic [WIDTH:0]   madd;
    logic [WIDTH-1:0] it_hi;
    logic [WIDTH-1:0] it_lo;
`ifdef ALU_SEQ_DIV_EN
    logic [WIDTH:0]   dshift;
`endif

    // Single-cycle opcode decode and evaluation
    always_comb begin
        sum       = '0;
        sc_res    = '0;
        sc_hi     = '0;
        sc_c      = 1'b0;
        sc_keep_c = 1'b0;
        sc_iter   = 1'b0;
        case (sel_i)
            OP_ADD: begin
                sum    = {1'b0, a_i} + {1'b0, b_i};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_ADDC: begin
                sum    = {1'b0, a_i} + {1'b0, b_i} + W1'(cin_i);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                sum    = {1'b0, a_i} - {1'b0, b_i};
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_SUBC: begin
                sum    = {1'b0, a_i} - {1'b0, b_i} - W1'(cin_i);
                sc_res = sum[WIDTH-1:0];
                sc_c   = sum[WIDTH];
            end
            OP_AND, OP_TEST: sc_res = a_i & b_i;
            OP_OR:           sc_res = a_i | b_i;
            OP_XOR:          sc_res = a_i ^ b_i;
            OP_LSL: {sc_c, sc_res} = {a_i, cin_i};
            OP_LSR: begin
                sc_c   = a_i[0];
                sc_res = {cin_i, a_i[WIDTH-1:1]};
            end
            OP_ROL: begin
                sc_c   = a_i[WIDTH-1];
                sc_res = {a_i[WIDTH-2:0], a_i[WIDTH-1]};
            end
            OP_ROR: begin
                sc_c   = a_i[0];
                sc_res = {a_i[0], a_i[WIDTH-1:1]};
            end
            OP_ASR: begin
                sc_c   = a_i[0];
                sc_res = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
            end
            OP_MOV: begin
                sc_res    = a_i;
                sc_keep_c = 1'b1;
            end
            OP_MUL: sc_iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
            OP_DIV: begin
                if (b_i == '0) begin
                    // Divide by zero finishes immediately with a saturated quotient
                    sc_res = '1;
                    sc_hi  = a_i;
                    sc_c   = 1'b1;
                end else begin
                    sc_iter = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // One shift-add (or restoring-divide) step on the working registers
    always_comb begin
        madd  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        it_hi = madd[WIDTH:1];
        it_lo = {madd[0], lo_q[WIDTH-1:1]};
`ifdef ALU_SEQ_DIV_EN
        dshift = {hi_q, lo_q[WIDTH-1]};
        if (is_div_q) begin
            if (dshift >= {1'b0, opb_q}) begin
                it_hi = WIDTH'(dshift - {1'b0, opb_q});
                it_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                it_hi = dshift[WIDTH-1:0];
                it_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        c_d         = c_q;
        z_d         = z_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
`ifdef ALU_SEQ_DIV_EN
        is_div_d    = is_div_q;
`endif
        if (state_q == S_RUN) begin
            hi_d  = it_hi;
            lo_d  = it_lo;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
                state_d     = S_IDLE;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                result_d    = it_lo;
                result_hi_d = it_hi;
                c_d         = |it_hi;
                z_d         = ~|{it_hi, it_lo};
`ifdef ALU_SEQ_DIV_EN
                if (is_div_q) begin
                    c_d = 1'b0;
                    z_d = ~|it_lo;
                end
`endif
            end
        end else if (start_i) begin
            if (sc_iter) begin
                state_d = S_RUN;
                busy_d  = 1'b1;
                cnt_d   = '0;
                hi_d    = '0;
                lo_d    = a_i;
                opb_d   = b_i;
`ifdef ALU_SEQ_DIV_EN
                is_div_d = sel_i[0];
`endif
            end else begin
                done_d      = 1'b1;
                result_d    = sc_res;
                result_hi_d = sc_hi;
                c_d         = sc_keep_c ? c_q : sc_c;
                z_d         = ~|sc_res;
            end
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            c_q         <= c_d;
            z_q         <= z_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
`ifdef ALU_SEQ_DIV_EN
            is_div_q    <= is_div_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign c_o         = c_q;
    assign z_o         = z_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=8): directed vector table, hand-written
// multi-cycle/reset sequences and randomized ops against a reference model.
module tb_alu_seq;

    localparam int TW = 8;
    localparam int M  = 1 << TW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [4:0]    sel;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic          busy;
    logic          done;
    logic [TW-1:0] res;
    logic [TW-1:0] res_hi;
    logic          c;
    logic          z;

    int n_checks = 0;
    int n_fail   = 0;

    alu_seq #(.WIDTH(TW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start),
        .sel_i      (sel),
        .a_i        (a),
        .b_i        (b),
        .cin_i      (cin),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (res),
        .result_hi_o(res_hi),
        .c_o        (c),
        .z_o        (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    sel;
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          cin;
        logic [TW-1:0] res;
        logic          c;
        logic          z;
    } vec_t;

    typedef struct {
        int res;
        int hi;
        bit c;
        bit z;
        bit multi;
    } exp_t;

    vec_t vt[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour from the opcode definitions using integer arithmetic
    function automatic exp_t model(input int s, input int av, input int bv, input int ci, input bit cprev);
        exp_t e;
        int full;
        e = '{0, 0, 1'b0, 1'b0, 1'b0};
        full = 0;
        case (s)
            0:  full = av + bv;
            1:  full = av + bv + ci;
            2, 4: full = (av - bv + 2 * M) % (2 * M);
            3:  full = (av - bv - ci + 2 * M) % (2 * M);
            5, 8: full = av & bv;
            6:  full = av | bv;
            7:  full = av ^ bv;
            9:  full = av * 2 + ci;
            10: full = (av % 2) * M + av / 2 + ci * (M / 2);
            11: full = (av / (M / 2)) * M + (av * 2) % M + av / (M / 2);
            12: full = (av % 2) * M + av / 2 + (av % 2) * (M / 2);
            13: full = (av % 2) * M + av / 2 + ((av >= M / 2) ? M / 2 : 0);
            14: full = av + (cprev ? M : 0);
            default: full = 0;
        endcase
        e.res = full % M;
        e.c   = (full / M) != 0;
        e.z   = (e.res == 0);
        if (s == 16) begin
            e.res   = (av * bv) % M;
            e.hi    = (av * bv) / M;
            e.c     = e.hi != 0;
            e.z     = (av * bv) == 0;
            e.multi = 1'b1;
        end
`ifdef ALU_SEQ_DIV_EN
        if (s == 17) begin
            if (bv == 0) begin
                e.res = M - 1;
                e.hi  = av;
                e.c   = 1'b1;
                e.z   = 1'b0;
            end else begin
                e.res   = av / bv;
                e.hi    = av % bv;
                e.c     = 1'b0;
                e.z     = (av / bv) == 0;
                e.multi = 1'b1;
            end
        end
`endif
        return e;
    endfunction

    // Issue one op and wait (bounded) for DONE; operands are scrambled while busy
    task automatic run_op(input logic [4:0] s, input logic [TW-1:0] av, input logic [TW-1:0] bv,
                          input logic ci, output int cyc, output int bcnt);
        sel = s; a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            a = TW'($urandom);
            b = TW'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic check_out(input string name, input exp_t e);
        check({name, "_res"}, 32'(res), 32'(e.res));
        check({name, "_hi"},  32'(res_hi), 32'(e.hi));
        check({name, "_c"},   32'(c), 32'(e.c));
        check({name, "_z"},   32'(z), 32'(e.z));
    endtask

    initial begin
        int cyc;
        int bcnt;
        int dcnt;
        bit cprev;
        exp_t e;
        logic [4:0] rs;
        logic [TW-1:0] ra;
        logic [TW-1:0] rb;
        logic rc;
        int r;

        rst_n = 1'b0; start = 1'b0; sel = '0; a = '0; b = '0; cin = 1'b0;

        vt[0]  = '{5'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[1]  = '{5'd3,  8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vt[2]  = '{5'd14, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[3]  = '{5'd11, 8'h81, 8'h00, 1'b0, 8'h03, 1'b1, 1'b0};
        vt[4]  = '{5'd13, 8'h81, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0};
        vt[5]  = '{5'd10, 8'h01, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0};
        vt[6]  = '{5'd1,  8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b1};
        vt[7]  = '{5'd2,  8'h05, 8'h06, 1'b0, 8'hFF, 1'b1, 1'b0};
        vt[8]  = '{5'd4,  8'h06, 8'h05, 1'b0, 8'h01, 1'b0, 1'b0};
        vt[9]  = '{5'd5,  8'hF0, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[10] = '{5'd6,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        vt[11] = '{5'd7,  8'hAA, 8'hFF, 1'b0, 8'h55, 1'b0, 1'b0};
        vt[12] = '{5'd8,  8'h3C, 8'h0F, 1'b0, 8'h0C, 1'b0, 1'b0};
        vt[13] = '{5'd9,  8'h80, 8'h00, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[14] = '{5'd12, 8'h01, 8'h00, 1'b0, 8'h80, 1'b1, 1'b0};
        vt[15] = '{5'd15, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[16] = '{5'd31, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1};
        vt[17] = '{5'd14, 8'h55, 8'h00, 1'b1, 8'h55, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_res", 32'(res), 32'd0);
        check("rst_hi", 32'(res_hi), 32'd0);
        check("rst_c", 32'(c), 32'd0);
        check("rst_z", 32'(z), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed single-cycle vectors, issued back-to-back
        for (int i = 0; i < 18; i++) begin
            sel = vt[i].sel; a = vt[i].a; b = vt[i].b; cin = vt[i].cin; start = 1'b1;
            @(posedge clk); #1;
            check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d_res", i), 32'(res), 32'(vt[i].res));
            check($sformatf("vec%0d_hi", i), 32'(res_hi), 32'd0);
            check($sformatf("vec%0d_c", i), 32'(c), 32'(vt[i].c));
            check($sformatf("vec%0d_z", i), 32'(z), 32'(vt[i].z));
        end
        start = 1'b0;
        @(posedge clk); #1;
        check("idle_done_low", 32'(done), 32'd0);
        check("idle_res_hold", 32'(res), 32'h55);

        // MUL 0xFF*0xFF with ignored STARTs during BUSY and at the final edge
        sel = 5'd16; a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        cyc = 0; bcnt = 0; dcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            start = (cyc == 2 || cyc == 7);
            sel = 5'd0; a = 8'h01; b = 8'h01;
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("mul_done", 32'(done), 32'd1);
        check("mul_busy_cycles", 32'(bcnt), 32'd8);
        check("mul_latency", 32'(cyc), 32'd8);
        check("mul_busy_end", 32'(busy), 32'd0);
        check_out("mul_ff", '{1, 8'hFE, 1'b1, 1'b0, 1'b1});
        @(posedge clk); #1;
        check("mul_no_extra_done", 32'(done), 32'd0);
        check("mul_res_hold", 32'(res), 32'h01);

        // Reset asserted on the 4th BUSY cycle of a MUL
        sel = 5'd16; a = 8'hC3; b = 8'h5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_res", 32'(res), 32'd0);
        check("mid_rst_hi", 32'(res_hi), 32'd0);
        check("mid_rst_c", 32'(c), 32'd0);
        check("mid_rst_z", 32'(z), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        dcnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        check("post_rst_quiet", 32'(dcnt), 32'd0);
        run_op(5'd0, 8'h01, 8'h02, 1'b0, cyc, bcnt);
        check("post_rst_add_lat", 32'(cyc), 32'd0);
        check_out("post_rst_add", '{3, 0, 1'b0, 1'b0, 1'b0});

        // Divide opcode, with and without the divider compiled in
`ifdef ALU_SEQ_DIV_EN
        run_op(5'd17, 8'hC8, 8'h07, 1'b0, cyc, bcnt);
        check("div_busy_cycles", 32'(bcnt), 32'd8);
        check("div_latency", 32'(cyc), 32'd8);
        check_out("div_c8_7", '{8'h1C, 8'h04, 1'b0, 1'b0, 1'b1});
        run_op(5'd17, 8'hC8, 8'h00, 1'b0, cyc, bcnt);
        check("div0_latency", 32'(cyc), 32'd0);
        check("div0_busy", 32'(bcnt), 32'd0);
        check_out("div0", '{8'hFF, 8'hC8, 1'b1, 1'b0, 1'b0});
`else
        run_op(5'd17, 8'hC8, 8'h07, 1'b0, cyc, bcnt);
        check("div_off_latency", 32'(cyc), 32'd0);
        check("div_off_busy", 32'(bcnt), 32'd0);
        check_out("div_off", '{0, 0, 1'b0, 1'b1, 1'b0});
`endif

        // Randomized ops against the model
        run_op(5'd0, 8'h00, 8'h00, 1'b0, cyc, bcnt);
        cprev = 1'b0;
        for (int i = 0; i < 200; i++) begin
            r  = int'($urandom_range(0, 39));
            rs = (r > 31) ? ((r % 2 == 1) ? 5'd16 : 5'd17) : 5'(r);
            ra = TW'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom);
            rc = 1'($urandom);
            e  = model(int'(rs), int'(ra), int'(rb), int'(rc), cprev);
            run_op(rs, ra, rb, rc, cyc, bcnt);
            check($sformatf("rnd%0d_lat", i), 32'(cyc), e.multi ? 32'd8 : 32'd0);
            check_out($sformatf("rnd%0d_op%0d", i, rs), e);
            cprev = e.c;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
